// File: rtl/clk_gate_ctrl_if.sv
// Request/grant bundle between the requesters and the gated-clock enable sequencer.
// The requester side drives req/force_on and observes the grant and enable state.
interface clk_gate_ctrl_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0] req;
  logic             force_on;
  logic [N_REQ-1:0] ack;
  logic             clken;
  logic             clk_active;

  modport master (
    output req,
    output force_on,
    input  ack,
    input  clken,
    input  clk_active
  );

  modport slave (
    input  req,
    input  force_on,
    output ack,
    output clken,
    output clk_active
  );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Enable sequencer for a single gated-clock cell: wake/settle before grant,
// idle timeout before gating off, and a minimum off time before re-waking.
module clk_gate_ctrl #(
  parameter int N_REQ       = 4,
  parameter int WAKE_CYCLES = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int MIN_OFF     = 2
) (
  input  logic            clkin,
  input  logic            rst,
  clk_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_WAKE = 2'd1,
    ST_ON   = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);
  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] OFF_LOAD  = 8'(MIN_OFF - 1);

  localparam bit PARAMS_OK = (N_REQ >= 1) && (N_REQ <= 8) &&
                             (WAKE_CYCLES >= 1) && (WAKE_CYCLES <= 255) &&
                             (IDLE_CYCLES >= 1) && (IDLE_CYCLES <= 255) &&
                             (MIN_OFF >= 1) && (MIN_OFF <= 255);

  state_e     state_q, state_d;
  logic [7:0] wake_cnt_q, wake_cnt_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] off_cnt_q, off_cnt_d;
  logic       clken_q, clken_d;
  logic       any_req;

  assign any_req = (|bus.req) | bus.force_on;

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q    <= ST_OFF;
      wake_cnt_q <= 8'd0;
      idle_cnt_q <= 8'd0;
      off_cnt_q  <= 8'd0;
      clken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      off_cnt_q  <= off_cnt_d;
      clken_q    <= clken_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    idle_cnt_d = idle_cnt_q;
    off_cnt_d  = off_cnt_q;
    unique case (state_q)
      ST_OFF: begin
        if (any_req) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
        end
      end
      ST_WAKE: begin
        // WAKE runs its full length regardless of req so the clock has settled before any grant
        if (wake_cnt_q == 8'd0) begin
          state_d    = ST_ON;
          idle_cnt_d = 8'd0;
        end else begin
          wake_cnt_d = wake_cnt_q - 8'd1;
        end
      end
      ST_ON: begin
        if (any_req) begin
          idle_cnt_d = 8'd0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d   = ST_HOLD;
          off_cnt_d = OFF_LOAD;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (off_cnt_q == 8'd0) begin
          if (any_req) begin
            state_d    = ST_WAKE;
            wake_cnt_d = WAKE_LOAD;
          end else begin
            state_d = ST_OFF;
          end
        end else begin
          off_cnt_d = off_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_OFF;
    endcase
    // Registered from the next state so clken mirrors WAKE/ON without any combinational path
    clken_d = (state_d == ST_WAKE) || (state_d == ST_ON);
  end

  always_comb begin
    bus.ack        = (state_q == ST_ON) ? bus.req : '0;
    bus.clk_active = (state_q == ST_ON);
    bus.clken      = clken_q;
  end

  param_range_chk: assert property (@(posedge clkin) PARAMS_OK)
    else $error("clk_gate_ctrl: parameter out of range");

endmodule
